// File: rtl/led_arbiter.sv
// Round-robin sharing of the 8-bit LED bank among four requesters: each grant shows one
// pattern for max(dur,1) cycles, then GAP_CYCLES of IDLE_PAT. Optional LED_ARB_PREEMPT_EN.
`timescale 1ns/1ps
module led_arbiter #(
   parameter logic [7:0]  IDLE_PAT   = 8'hff,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req_i,
   input  logic [31:0] pat_i,
   input  logic [63:0] dur_i,
   output logic [3:0]  gnt_o,
   output logic [3:0]  done_o,
   output logic [3:0]  abort_o,
   output logic        busy_o,
   output logic [7:0]  led_o
);

   typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

   localparam logic [15:0] GAP_LOAD = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

   state_t      r_state, w_state_nxt;
   logic [15:0] r_cnt, w_cnt_nxt;
   logic [1:0]  r_ptr, w_ptr_nxt;
   logic [7:0]  r_led, w_led_nxt;
   logic [3:0]  r_gnt, w_gnt_nxt;
   logic [3:0]  r_done, w_done_nxt;
   logic [1:0]  w_win, w_idx;
   logic        w_found;
`ifdef LED_ARB_PREEMPT_EN
   logic [3:0]  r_abort, w_abort_nxt;
`endif

   // Counter holds remaining cycles minus one, so a zero duration still shows once.
   function automatic logic [15:0] f_load(input logic [15:0] d);
      return (d == 16'd0) ? 16'd0 : d - 16'd1;
   endfunction

   always_comb begin
      w_win   = r_ptr;
      w_idx   = r_ptr;
      w_found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w_idx = r_ptr + 2'(i);
         if (!w_found && req_i[w_idx]) begin
            w_win   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_led   <= IDLE_PAT;
         r_gnt   <= '0;
         r_done  <= '0;
`ifdef LED_ARB_PREEMPT_EN
         r_abort <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ptr   <= w_ptr_nxt;
         r_led   <= w_led_nxt;
         r_gnt   <= w_gnt_nxt;
         r_done  <= w_done_nxt;
`ifdef LED_ARB_PREEMPT_EN
         r_abort <= w_abort_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ptr_nxt   = r_ptr;
      w_led_nxt   = r_led;
      w_gnt_nxt   = r_gnt;
`ifdef LED_ARB_PREEMPT_EN
      w_abort_nxt = '0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_SHOW;
               w_led_nxt   = pat_i[{w_win, 3'b000} +: 8];
               w_cnt_nxt   = f_load(dur_i[{w_win, 4'b0000} +: 16]);
               w_gnt_nxt   = 4'b0001 << w_win;
               w_ptr_nxt   = w_win + 2'd1;
            end
         end
         S_SHOW: begin
`ifdef LED_ARB_PREEMPT_EN
            // Urgent requester 0 takes over mid-display; the last cycle always completes.
            if (req_i[0] && !r_gnt[0] && r_cnt != 16'd0) begin
               w_led_nxt   = pat_i[7:0];
               w_cnt_nxt   = f_load(dur_i[15:0]);
               w_gnt_nxt   = 4'b0001;
               w_abort_nxt = r_gnt;
            end else
`endif
            if (r_cnt == 16'd0) begin
               w_led_nxt   = IDLE_PAT;
               w_gnt_nxt   = '0;
               w_cnt_nxt   = GAP_LOAD;
               w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end else begin
               w_cnt_nxt = r_cnt - 16'd1;
            end
         end
         S_GAP: begin
            if (r_cnt == 16'd0) w_state_nxt = S_IDLE;
            else                w_cnt_nxt   = r_cnt - 16'd1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_done_nxt = (w_state_nxt == S_SHOW && w_cnt_nxt == 16'd0) ? w_gnt_nxt : 4'b0000;
      gnt_o      = r_gnt;
      done_o     = r_done;
      led_o      = r_led;
      busy_o     = (r_state != S_IDLE);
`ifdef LED_ARB_PREEMPT_EN
      abort_o    = r_abort;
`else
      abort_o    = 4'b0000;
`endif
   end

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter: two instances (GAP 0 and GAP 3) driven by requester
// agents; a display-level model predicts every cycle, a monitor compares.
`timescale 1ns/1ps
module tb_led_arbiter;

   localparam logic [7:0] IDLE = 8'hff;
`ifdef LED_ARB_PREEMPT_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] led;
      logic [3:0] gnt;
      logic [3:0] done;
      logic [3:0] abort;
      logic       busy;
   } obs_t;

   typedef struct {
      int         inst;
      int         rq;
      logic [7:0] pat;
      logic [15:0] dur;
      int         start;
   } job_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0]  req [2];
   logic [31:0] pat [2];
   logic [63:0] dur [2];
   logic [3:0]  gnt0, gnt1, done0, done1, abort0, abort1;
   logic        busy0, busy1;
   logic [7:0]  led0, led1;

   led_arbiter #(.IDLE_PAT(IDLE), .GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_i(req[0]), .pat_i(pat[0]), .dur_i(dur[0]),
      .gnt_o(gnt0), .done_o(done0), .abort_o(abort0), .busy_o(busy0), .led_o(led0));

   led_arbiter #(.IDLE_PAT(IDLE), .GAP_CYCLES(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_i(req[1]), .pat_i(pat[1]), .dur_i(dur[1]),
      .gnt_o(gnt1), .done_o(done1), .abort_o(abort1), .busy_o(busy1), .led_o(led1));

   always #5 clk = ~clk;

   int         m_owner [2];
   int         m_rem   [2];
   int         m_gap   [2];
   int         m_ptr   [2];
   logic [7:0] m_pat   [2];
   logic [3:0] m_abort [2];
   obs_t       q0[$], q1[$];
   job_t       jobs[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   function automatic int gap_of(input int k);
      return (k == 0) ? 0 : 3;
   endfunction

   function automatic obs_t get_obs(input int k);
      obs_t o;
      if (k == 0) o = '{led: led0, gnt: gnt0, done: done0, abort: abort0, busy: busy0};
      else        o = '{led: led1, gnt: gnt1, done: done1, abort: abort1, busy: busy1};
      return o;
   endfunction

   function automatic int find_job(input int k, input int n);
      for (int i = 0; i < jobs.size(); i++)
         if (jobs[i].inst == k && jobs[i].rq == n) return i;
      return -1;
   endfunction

   task automatic add_job(input int k, input int n, input logic [7:0] p, input logic [15:0] d,
                          input int st);
      job_t j;
      j = '{inst: k, rq: n, pat: p, dur: d, start: st};
      jobs.push_back(j);
   endtask

   // Requester behaviour: hold req until done, drop for the edge ending done, scramble
   // pattern/duration once granted (they are sampled only at grant).
   task automatic agent(input int k);
      obs_t o;
      int   j;
      o = get_obs(k);
      for (int n = 0; n < 4; n++) begin
         j = find_job(k, n);
         if (req[k][n] && o.done[n]) begin
            if (j >= 0) jobs.delete(j);
            req[k][n] = 1'b0;
         end else if (req[k][n] && o.abort[n] && j >= 0) begin
            pat[k][n*8 +: 8]   = jobs[j].pat;
            dur[k][n*16 +: 16] = jobs[j].dur;
         end else if (req[k][n] && o.gnt[n]) begin
            pat[k][n*8 +: 8]   = 8'($urandom);
            dur[k][n*16 +: 16] = 16'($urandom_range(0, 7));
         end else if (!req[k][n] && j >= 0 && jobs[j].start <= cyc) begin
            req[k][n]          = 1'b1;
            pat[k][n*8 +: 8]   = jobs[j].pat;
            dur[k][n*16 +: 16] = jobs[j].dur;
         end
      end
   endtask

   // Display-level model: who owns the LEDs, how many display/gap cycles remain.
   task automatic model_step(input int k);
      obs_t        e;
      logic [15:0] d;
      bit          found;
      int          c;
      m_abort[k] = 4'b0000;
      if (m_owner[k] >= 0) begin
         if (PRE && req[k][0] && m_owner[k] != 0 && m_rem[k] > 1) begin
            m_abort[k] = 4'(1 << m_owner[k]);
            m_owner[k] = 0;
            m_pat[k]   = pat[k][7:0];
            d          = dur[k][15:0];
            m_rem[k]   = (d == 0) ? 1 : int'(d);
         end else if (m_rem[k] == 1) begin
            m_owner[k] = -1;
            m_gap[k]   = gap_of(k);
         end else begin
            m_rem[k]--;
         end
      end else if (m_gap[k] > 0) begin
         m_gap[k]--;
      end else if (req[k] != 4'b0000) begin
         found = 1'b0;
         for (int i = 0; i < 4; i++) begin
            c = (m_ptr[k] + i) % 4;
            if (!found && req[k][c]) begin
               found      = 1'b1;
               m_owner[k] = c;
               m_pat[k]   = pat[k][c*8 +: 8];
               d          = dur[k][c*16 +: 16];
               m_rem[k]   = (d == 0) ? 1 : int'(d);
               m_ptr[k]   = (c + 1) % 4;
            end
         end
      end
      e.led   = (m_owner[k] >= 0) ? m_pat[k] : IDLE;
      e.gnt   = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0000;
      e.done  = (m_owner[k] >= 0 && m_rem[k] == 1) ? e.gnt : 4'b0000;
      e.abort = m_abort[k];
      e.busy  = (m_owner[k] >= 0) || (m_gap[k] > 0);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Stimulus + prediction, once per cycle on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_rem[k] = 0; m_gap[k] = 0; m_ptr[k] = 0;
            m_pat[k] = IDLE; m_abort[k] = 4'b0000;
            req[k] = 4'b0000; pat[k] = '0; dur[k] = '0;
         end
         jobs.delete();
      end else begin
         cyc++;
         for (int k = 0; k < 2; k++) begin
            agent(k);
            model_step(k);
         end
      end
   end

   // Monitor: reset values while rst_n is low (checked right after it falls), else scoreboard.
   always begin
      obs_t got, exp_o;
      @(posedge clk or negedge rst_n);
      #2;
      for (int k = 0; k < 2; k++) begin
         got = get_obs(k);
         if (!rst_n) begin
            exp_o = '{led: IDLE, gnt: 4'b0000, done: 4'b0000, abort: 4'b0000, busy: 1'b0};
         end else if (k == 0 && q0.size() > 0) begin
            exp_o = q0.pop_front();
         end else if (k == 1 && q1.size() > 0) begin
            exp_o = q1.pop_front();
         end else begin
            continue;
         end
         checks++;
         if (got !== exp_o) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d: got led=%h gnt=%b done=%b abort=%b busy=%b want led=%h gnt=%b done=%b abort=%b busy=%b",
                     rst_n ? "scoreboard" : "reset", k, cyc, got.led, got.gnt, got.done,
                     got.abort, got.busy, exp_o.led, exp_o.gnt, exp_o.done, exp_o.abort, exp_o.busy);
         end
      end
      if (!rst_n) begin
         q0.delete();
         q1.delete();
      end
   end

   task automatic wait_idle(input int budget, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         #1;
         ok = (jobs.size() == 0) && (req[0] == 4'b0000) && (req[1] == 4'b0000) && !busy0 && !busy1;
      end
      if (!ok) begin
         $display("FAIL timeout %s: got still busy after %0d cycles, want idle", tag, budget);
         $fatal(1, "timeout");
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;

      // single request (GAP 0), and zero-duration displays back to back (GAP 3)
      add_job(0, 1, 8'h3c, 16'd5, cyc + 1);
      add_job(1, 2, 8'ha5, 16'd0, cyc + 1);
      add_job(1, 3, 8'h5a, 16'd0, cyc + 1);
      wait_idle(400, "single");

      // all four requesting continuously, dur 2
      for (int r = 0; r < 3; r++)
         for (int n = 0; n < 4; n++)
            for (int k = 0; k < 2; k++)
               add_job(k, n, 8'(16 * n + r + 1), 16'd2, cyc + 1);
      wait_idle(800, "round_robin");

      // long display of requester 2 with requester 0 arriving midway
      for (int k = 0; k < 2; k++) begin
         add_job(k, 2, 8'hc3, 16'd100, cyc + 1);
         add_job(k, 0, 8'h81, 16'd4, cyc + 52);
      end
      wait_idle(2000, "urgent");

      // asynchronous reset in the middle of a display
      add_job(0, 1, 8'h77, 16'd40, cyc + 1);
      add_job(1, 3, 8'h66, 16'd40, cyc + 1);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
      wait_idle(100, "after_reset");

      // randomized traffic
      for (int i = 0; i < 60; i++)
         add_job(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 8'($urandom),
                 16'($urandom_range(0, 12)), cyc + int'($urandom_range(0, 300)));
      wait_idle(6000, "random");

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
